// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with memory req/ready handshake
//
// Sequences the shared datapath over several cycles per instruction.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   opcode, funct         IR[31:26], IR[5:0]
//   zero                  ALU zero flag (same cycle)
//   mem_ready             memory completes the current access at this edge
//   mem_req/mem_write/iord  memory request, write, address select (1=ALUOut, 0=PC)
//   ir_write/pc_write/reg_write  register enables
//   alu_src_a/alu_src_b/alu_op   ALU operand selects and operation
//   pc_src/reg_dst/mem_to_reg    datapath mux selects
//   retire                one-cycle pulse in an instruction's last state
//   halted                illegal instruction seen
//   state                 current state (debug)
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       retire,
  output logic       halted,
  output logic [3:0] state
);

  // ALU operation codes; ADD is 0 so the all-zero reset/default vector means ADD.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] EXEC_R = 4'd2;
  localparam logic [3:0] EXEC_I = 4'd3;
  localparam logic [3:0] WB_ALU = 4'd4;
  localparam logic [3:0] ADDR   = 4'd5;
  localparam logic [3:0] MEM_RD = 4'd6;
  localparam logic [3:0] WB_MEM = 4'd7;
  localparam logic [3:0] MEM_WR = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;
  localparam logic [3:0] JUMP   = 4'd10;
  localparam logic [3:0] JAL    = 4'd11;
  localparam logic [3:0] HALT   = 4'd15;

  logic [3:0] state_q;
  logic [3:0] next_state;
  logic       r_legal;
  logic [2:0] r_op;

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= next_state;
  end

  // R-type funct decode: legality and ALU operation.
  always_comb begin
    r_legal = 1'b1;
    r_op    = OP_ADD;
    case (funct)
      6'h00:   r_op = OP_SLL;
      6'h02:   r_op = OP_SRL;
      6'h20:   r_op = OP_ADD;
      6'h22:   r_op = OP_SUB;
      6'h24:   r_op = OP_AND;
      6'h25:   r_op = OP_OR;
      6'h27:   r_op = OP_NOR;
      6'h2A:   r_op = OP_SLT;
      default: r_legal = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 3'd0;
    alu_op     = OP_ADD;
    pc_src     = 2'd0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    retire     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 3'd1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 3'd4;
        case (opcode)
          6'h00:               next_state = r_legal ? EXEC_R : HALT;
          6'h08, 6'h0C, 6'h0D: next_state = EXEC_I;
          6'h23, 6'h2B:        next_state = ADDR;
          6'h04, 6'h05:        next_state = BRANCH;
          6'h02:               next_state = JUMP;
          6'h03:               next_state = JAL;
          default:             next_state = HALT;
        endcase
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = r_op;
        next_state = WB_ALU;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        case (opcode)
          6'h0C: begin alu_src_b = 3'd3; alu_op = OP_AND; end
          6'h0D: begin alu_src_b = 3'd3; alu_op = OP_OR;  end
          default: alu_src_b = 3'd2;
        endcase
        next_state = WB_ALU;
      end
      WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == 6'h00) ? 2'd1 : 2'd0;
        retire     = 1'b1;
        next_state = FETCH;
      end
      ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 3'd2;
        next_state = (opcode == 6'h23) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) next_state = WB_MEM;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        retire     = 1'b1;
        next_state = FETCH;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = OP_SUB;
        pc_src     = 2'd1;
        retire     = 1'b1;
        pc_write   = ((opcode == 6'h04) && zero) || ((opcode == 6'h05) && !zero);
        next_state = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        retire     = 1'b1;
        next_state = FETCH;
      end
      JAL: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        retire     = 1'b1;
        next_state = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: next_state = FETCH;
    endcase

    // Reset overrides every control output so an in-flight access is dropped
    // in the same cycle; the state register itself is cleared at the edge.
    if (reset) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 3'd0;
      alu_op     = OP_ADD;
      pc_src     = 2'd0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      retire     = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3;
  localparam logic [2:0] A_NOR = 3'd4, A_SLT = 3'd5, A_SLL = 3'd6, A_SRL = 3'd7;

  typedef struct packed {
    logic       mem_req, mem_write, iord, ir_write, pc_write, reg_write, alu_src_a;
    logic [2:0] alu_src_b, alu_op;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
    logic       retire, halted;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    ctl_t       c;
  } step_t;

  logic clk = 0, reset = 1, zero = 0, mem_ready = 0;
  logic [5:0] opcode = 0, funct = 0;
  logic mem_req, mem_write, iord, ir_write, pc_write, reg_write, alu_src_a;
  logic [2:0] alu_src_b, alu_op;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic retire, halted;
  logic [3:0] state;
  ctl_t obs;

  int checks = 0, fails = 0;
  int retires_seen = 0, legal_done = 0;
  step_t q[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .retire(retire), .halted(halted),
    .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_write, iord, ir_write, pc_write, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg, retire, halted};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h00: return A_SLL;
      6'h02: return A_SRL;
      6'h22: return A_SUB;
      6'h24: return A_AND;
      6'h25: return A_OR;
      6'h27: return A_NOR;
      6'h2A: return A_SLT;
      default: return A_ADD;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00)
      return fn inside {6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    return op inside {6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input ctl_t c);
    step_t s;
    s.st = st; s.mr = mr; s.c = c;
    q.push_back(s);
  endtask

  // Expected per-cycle trace of one instruction: wf/wm wait cycles on the
  // instruction fetch and data access. Non-memory cycles get a random
  // mem_ready, which the controller must ignore.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int wf, input int wm);
    ctl_t c;
    q.delete();
    c = '0; c.mem_req = 1; c.alu_src_b = 3'd1;
    for (int i = 0; i < wf; i++) push(4'd0, 1'b0, c);
    c.ir_write = 1; c.pc_write = 1;
    push(4'd0, 1'b1, c);
    c = '0; c.alu_src_b = 3'd4;
    push(4'd1, 1'($urandom), c);
    if (!is_legal(op, fn)) begin
      c = '0; c.halted = 1;
      push(4'd15, 1'($urandom), c);
    end else if (op == 6'h00 || op == 6'h08 || op == 6'h0C || op == 6'h0D) begin
      c = '0; c.alu_src_a = 1;
      if (op == 6'h00) begin c.alu_src_b = 3'd0; c.alu_op = r_alu(fn); end
      else if (op == 6'h08) begin c.alu_src_b = 3'd2; c.alu_op = A_ADD; end
      else if (op == 6'h0C) begin c.alu_src_b = 3'd3; c.alu_op = A_AND; end
      else begin c.alu_src_b = 3'd3; c.alu_op = A_OR; end
      push((op == 6'h00) ? 4'd2 : 4'd3, 1'($urandom), c);
      c = '0; c.reg_write = 1; c.retire = 1; c.reg_dst = (op == 6'h00) ? 2'd1 : 2'd0;
      push(4'd4, 1'($urandom), c);
    end else if (op == 6'h23 || op == 6'h2B) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 3'd2; c.alu_op = A_ADD;
      push(4'd5, 1'($urandom), c);
      c = '0; c.mem_req = 1; c.iord = 1; c.mem_write = (op == 6'h2B);
      for (int i = 0; i < wm; i++) push((op == 6'h23) ? 4'd6 : 4'd8, 1'b0, c);
      c.retire = (op == 6'h2B);
      push((op == 6'h23) ? 4'd6 : 4'd8, 1'b1, c);
      if (op == 6'h23) begin
        c = '0; c.reg_write = 1; c.mem_to_reg = 2'd1; c.retire = 1;
        push(4'd7, 1'($urandom), c);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      c = '0; c.alu_src_a = 1; c.alu_op = A_SUB; c.pc_src = 2'd1; c.retire = 1;
      c.pc_write = (op == 6'h04) ? z : !z;
      push(4'd9, 1'($urandom), c);
    end else begin
      c = '0; c.pc_write = 1; c.pc_src = 2'd2; c.retire = 1;
      if (op == 6'h03) begin c.reg_write = 1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2; end
      push((op == 6'h03) ? 4'd11 : 4'd10, 1'($urandom), c);
    end
  endtask

  // Drive and check the first n steps of the queue (n<0: all of it).
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int n);
    int lim;
    lim = (n < 0) ? q.size() : n;
    opcode = op; funct = fn; zero = z;
    for (int i = 0; i < lim; i++) begin
      mem_ready = q[i].mr;
      @(negedge clk);
      chk({tag, ".state"}, 32'(state), 32'(q[i].st));
      chk({tag, ".ctl"}, 32'(obs), 32'(q[i].c));
      if (retire === 1'b1) retires_seen++;
      @(posedge clk); #1;
    end
    if (n < 0 && is_legal(op, fn)) legal_done++;
  endtask

  task automatic halt_hold(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      mem_ready = 1'($urandom);
      @(negedge clk);
      chk({tag, ".halt_state"}, 32'(state), 32'd15);
      chk({tag, ".halt_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".halted"}, 32'(halted), 32'd1);
      if (retire === 1'b1) retires_seen++;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1; mem_ready = 1'($urandom);
    @(negedge clk);
    chk({tag, ".rst_outputs"}, 32'(obs), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    chk({tag, ".rst_state"}, 32'(state), 32'd0);
  endtask

  int cyc;
  logic [5:0] op, fn;
  logic z;
  logic [5:0] legal_ops [10] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [5:0] r_fns [8] = '{6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

  initial begin
    // Reset: outputs all zero while held, FETCH after the edge.
    reset = 1; mem_ready = 1;
    @(negedge clk);
    chk("reset.outputs", 32'(obs), 32'd0);
    @(posedge clk); #1;
    chk("reset.state", 32'(state), 32'd0);
    reset = 0;

    // addi $s0,$zero,0xFEFE zero-wait: 0,1,3,4, retire on cycle 4.
    build(6'h08, 6'h3E, 0, 0, 0);
    chk("addi.cycles", 32'(q.size()), 32'd4);
    run("addi", 6'h08, 6'h3E, 0, -1);

    // lw with two wait cycles on fetch and on data read: 9 cycles.
    build(6'h23, 6'h00, 0, 2, 2);
    chk("lw.cycles", 32'(q.size()), 32'd9);
    run("lw", 6'h23, 6'h00, 0, -1);

    // bne $t1,$zero,-3 taken and not taken.
    build(6'h05, 6'h3D, 0, 0, 0);
    run("bne_taken", 6'h05, 6'h3D, 0, -1);
    build(6'h05, 6'h3D, 1, 0, 0);
    run("bne_not", 6'h05, 6'h3D, 1, -1);
    build(6'h04, 6'h00, 1, 1, 0);
    run("beq_taken", 6'h04, 6'h00, 1, -1);

    // jal and a plain sw.
    build(6'h03, 6'h00, 0, 0, 0);
    run("jal", 6'h03, 6'h00, 0, -1);
    build(6'h2B, 6'h00, 0, 0, 1);
    run("sw", 6'h2B, 6'h00, 0, -1);

    // Illegal opcode and illegal R-type funct.
    build(6'h3F, 6'h00, 0, 0, 0);
    run("ill_op", 6'h3F, 6'h00, 0, -1);
    halt_hold("ill_op", 20);
    do_reset("ill_op");
    build(6'h00, 6'h01, 0, 0, 0);
    run("ill_fn", 6'h00, 6'h01, 0, -1);
    halt_hold("ill_fn", 20);
    do_reset("ill_fn");

    // Reset while a store is waiting in MEM_WR.
    build(6'h2B, 6'h00, 0, 0, 3);
    run("sw_abort", 6'h2B, 6'h00, 0, 4);
    reset = 1; mem_ready = 1;
    @(negedge clk);
    chk("sw_abort.req_drop", 32'(mem_req), 32'd0);
    chk("sw_abort.outputs", 32'(obs), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    chk("sw_abort.state", 32'(state), 32'd0);
    mem_ready = 0;
    @(negedge clk);
    chk("sw_abort.no_write", 32'(mem_write), 32'd0);
    chk("sw_abort.fetch_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    // Finish that fetch as a zero-wait j so the FSM is back in FETCH.
    build(6'h02, 6'h00, 0, 0, 0);
    run("j", 6'h02, 6'h00, 0, -1);

    // Randomized instruction stream with random wait states.
    for (int k = 0; k < 60; k++) begin
      op = legal_ops[$urandom_range(0, 9)];
      fn = (op == 6'h00) ? r_fns[$urandom_range(0, 7)] : 6'($urandom);
      z  = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) begin op = 6'h00; fn = 6'h01; end
        else op = 6'h3F;
      end
      build(op, fn, z, $urandom_range(0, 2), $urandom_range(0, 2));
      cyc = q.size();
      run("rand", op, fn, z, -1);
      if (!is_legal(op, fn)) begin
        halt_hold("rand", 3);
        do_reset("rand");
      end
    end

    chk("retire_count", 32'(retires_seen), 32'(legal_done));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL timeout observed=running expected=finished");
  end

endmodule
